// File: rtl/adc_spi_pkg.sv
// Shared types and width helper for the ADC SPI receiver.
// No logic; latency and backpressure do not apply.
package adc_spi_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_edge_filter.sv
// 2-FF synchroniser plus glitch filter for one async level; level moves after FILT agreeing samples.
// Latency 2+FILT cycles from pin to level/rise/fall; no backpressure, edges are one-cycle pulses.
module spi_edge_filter
   import adc_spi_pkg::*;
#(
   parameter int   FILT        = 3,
   parameter logic RESET_LEVEL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = bits_for(FILT);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= RESET_LEVEL;
         sync2 <= RESET_LEVEL;
         level <= RESET_LEVEL;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= async_in;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         // Any sample matching the accepted level restarts the run count.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILT - 1)) begin
            level <= sync2;
            cnt   <= '0;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/adc_spi_multi_rx.sv
// SPI slave receiver for multi-channel ADC frames; words reported with channel index.
// data_valid FILT+3 cycles after the sampling SCLK edge; no backpressure, words are pulsed out.
module adc_spi_multi_rx
   import adc_spi_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int CHANNELS    = 4,
   parameter int SAMPLE_EDGE = 1,
   parameter int FILT        = 3
) (
   input  logic                          reset,
   input  logic                          clock,
   input  logic                          spi_nss,
   input  logic                          spi_clock_in,
   input  logic                          spi_data_in,
   output logic [WIDTH-1:0]              data_out,
   output logic [bits_for(CHANNELS)-1:0] channel,
   output logic                          data_valid,
   output logic                          frame_done,
   output logic                          frame_error,
   output logic                          busy
);

   localparam int   BW        = bits_for(WIDTH);
   localparam int   CHW       = bits_for(CHANNELS);
   localparam logic SCLK_IDLE = (SAMPLE_EDGE == 0);

   logic sclk_level, sclk_rise, sclk_fall;
   logic nss_level, nss_rise, nss_fall;

   spi_edge_filter #(.FILT(FILT), .RESET_LEVEL(SCLK_IDLE)) u_sclk_filter (
      .clock    (clock),
      .reset    (reset),
      .async_in (spi_clock_in),
      .level    (sclk_level),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   spi_edge_filter #(.FILT(FILT), .RESET_LEVEL(1'b1)) u_nss_filter (
      .clock    (clock),
      .reset    (reset),
      .async_in (spi_nss),
      .level    (nss_level),
      .rise     (nss_rise),
      .fall     (nss_fall)
   );

   // Only the filtered edges drive this receiver.
   logic unused_levels;
   assign unused_levels = sclk_level ^ nss_level;

   logic            mosi_s1, mosi_s2;
   logic [FILT-1:0] mosi_dly;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mosi_s1  <= 1'b0;
         mosi_s2  <= 1'b0;
         mosi_dly <= '0;
      end else begin
         mosi_s1     <= spi_data_in;
         mosi_s2     <= mosi_s1;
         mosi_dly[0] <= mosi_s2;
         for (int i = 1; i < FILT; i++) begin
            mosi_dly[i] <= mosi_dly[i-1];
         end
      end
   end

   logic             samp_edge;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic [BW-1:0]    bit_cnt;
   logic [CHW-1:0]   ch_cnt;
   state_t           state;

   assign samp_edge  = (SAMPLE_EDGE != 0) ? sclk_rise : sclk_fall;
   assign shift_next = {shift_reg[WIDTH-2:0], mosi_dly[FILT-1]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         ch_cnt      <= '0;
         data_out    <= '0;
         channel     <= '0;
         data_valid  <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         busy        <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               ch_cnt  <= '0;
               if (nss_fall) begin
                  state <= SHIFT;
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               // Deselect wins over a coincident sampling edge; that bit is dropped.
               if (nss_rise) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  frame_error <= (bit_cnt != '0);
                  bit_cnt     <= '0;
                  ch_cnt      <= '0;
               end else if (samp_edge) begin
                  shift_reg <= shift_next;
                  if (bit_cnt == BW'(WIDTH - 1)) begin
                     data_out   <= shift_next;
                     channel    <= ch_cnt;
                     data_valid <= 1'b1;
                     frame_done <= (ch_cnt == CHW'(CHANNELS - 1));
                     bit_cnt    <= '0;
                     ch_cnt     <= (ch_cnt == CHW'(CHANNELS - 1)) ? '0 : ch_cnt + CHW'(1);
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_multi_rx.sv
// Bench: two receivers (rising and falling sample edge) fed the same frames, checked against a bit-level model.
// The falling-edge receiver sees inverted SCLK, so MOSI changes on its rising edges.
module tb_adc_spi_multi_rx;

   localparam int WIDTH    = 16;
   localparam int CHANNELS = 4;
   localparam int FILT     = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic nss   = 1'b1;
   logic sclk  = 1'b0;
   logic mosi  = 1'b0;
   logic sclk_b;
   assign sclk_b = ~sclk;

   logic [WIDTH-1:0] a_do, b_do;
   logic [1:0]       a_ch, b_ch;
   logic             a_dv, a_fd, a_fe, a_busy;
   logic             b_dv, b_fd, b_fe, b_busy;

   adc_spi_multi_rx #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SAMPLE_EDGE(1), .FILT(FILT)) dut_a (
      .reset(reset), .clock(clock), .spi_nss(nss), .spi_clock_in(sclk), .spi_data_in(mosi),
      .data_out(a_do), .channel(a_ch), .data_valid(a_dv), .frame_done(a_fd),
      .frame_error(a_fe), .busy(a_busy)
   );

   adc_spi_multi_rx #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SAMPLE_EDGE(0), .FILT(FILT)) dut_b (
      .reset(reset), .clock(clock), .spi_nss(nss), .spi_clock_in(sclk_b), .spi_data_in(mosi),
      .data_out(b_do), .channel(b_ch), .data_valid(b_dv), .frame_done(b_fd),
      .frame_error(b_fe), .busy(b_busy)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [WIDTH-1:0] d;
      int               ch;
      bit               fd;
      int               ec;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   err_a = 0, err_b = 0, err_exp = 0;

   // Reference model: frame bit count, channel index, pending words.
   int               m_bits = 0;
   int               m_ch   = 0;
   logic [WIDTH-1:0] m_word = '0;
   int               half   = 8;

   always @(negedge clock) begin
      if (!reset) begin
         if (a_fe) err_a++;
         if (a_fd && !a_dv) chk("a_fd_without_dv", 32'(a_dv), 1);
         if (a_dv) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_word", 32'(qa.size()), 1);
            end else begin
               exp_t e;
               e = qa.pop_front();
               chk("a_data", a_do, e.d);
               chk("a_channel", a_ch, e.ch);
               chk("a_frame_done", a_fd, e.fd);
               chk("a_latency", cyc - e.ec, FILT + 3);
            end
         end
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (b_fe) err_b++;
         if (b_fd && !b_dv) chk("b_fd_without_dv", 32'(b_dv), 1);
         if (b_dv) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_word", 32'(qb.size()), 1);
            end else begin
               exp_t e;
               e = qb.pop_front();
               chk("b_data", b_do, e.d);
               chk("b_channel", b_ch, e.ch);
               chk("b_frame_done", b_fd, e.fd);
               chk("b_latency", cyc - e.ec, FILT + 3);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      mosi = b;
      if (glitch) begin
         step(5);
         sclk = 1'b1;
         step(1);
         sclk = 1'b0;
         step(half - 6);
      end else begin
         step(half);
      end
      sclk = 1'b1;
      m_word = {m_word[WIDTH-2:0], b};
      m_bits++;
      if (m_bits == WIDTH) begin
         exp_t e;
         e.d  = m_word;
         e.ch = m_ch;
         e.fd = (m_ch == CHANNELS - 1);
         e.ec = cyc;
         qa.push_back(e);
         qb.push_back(e);
         m_ch   = (m_ch + 1) % CHANNELS;
         m_bits = 0;
      end
      step(half);
      sclk = 1'b0;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input int nb, input bit glitch);
      for (int i = WIDTH - 1; i > WIDTH - 1 - nb; i--) send_bit(w[i], glitch);
   endtask

   task automatic nss_low();
      nss    = 1'b0;
      m_bits = 0;
      m_ch   = 0;
      step(12);
   endtask

   task automatic nss_high();
      step(4);
      nss = 1'b1;
      if (m_bits != 0) err_exp++;
      m_bits = 0;
      step(20);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_a_data"}, a_do, 0);
      chk({tag, "_a_channel"}, a_ch, 0);
      chk({tag, "_a_dv"}, a_dv, 0);
      chk({tag, "_a_fd"}, a_fd, 0);
      chk({tag, "_a_fe"}, a_fe, 0);
      chk({tag, "_a_busy"}, a_busy, 0);
      chk({tag, "_b_data"}, b_do, 0);
      chk({tag, "_b_channel"}, b_ch, 0);
      chk({tag, "_b_dv"}, b_dv, 0);
      chk({tag, "_b_fd"}, b_fd, 0);
      chk({tag, "_b_fe"}, b_fe, 0);
      chk({tag, "_b_busy"}, b_busy, 0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [WIDTH-1:0] w0, rw;
      int               nw;
      bit               gl;

      #12;
      check_zero("reset");
      step(3);
      reset = 1'b0;
      step(20);

      // Four channels in one frame; frame_done only on the last.
      half = 8;
      nss_low();
      send_word(16'h1234, WIDTH, 0);
      send_word(16'h5678, WIDTH, 0);
      send_word(16'h9ABC, WIDTH, 0);
      send_word(16'hDEF0, WIDTH, 0);
      nss_high();
      chk("hold_a_data", a_do, 16'hDEF0);
      chk("hold_b_channel", b_ch, 3);

      // Fifth word wraps to channel 0.
      nss_low();
      for (int i = 0; i < 5; i++) send_word(16'h1111 * 16'(i + 1), WIDTH, 0);
      nss_high();

      // Abort after 7 bits of channel 1.
      w0 = 16'h3C5A;
      nss_low();
      send_word(w0, WIDTH, 0);
      send_word(16'hFFFF, 7, 0);
      step(4);
      chk("abort_a_busy_before", a_busy, 1);
      nss = 1'b1;
      err_exp++;
      m_bits = 0;
      repeat (FILT + 4) @(negedge clock);
      chk("abort_a_fe", a_fe, 1);
      chk("abort_b_fe", b_fe, 1);
      chk("abort_a_busy", a_busy, 0);
      chk("abort_b_busy", b_busy, 0);
      chk("abort_a_data", a_do, w0);
      chk("abort_b_data", b_do, w0);
      chk("abort_a_channel", a_ch, 0);
      step(20);

      // Short SCLK glitches must be filtered out.
      half = 10;
      nss_low();
      send_word(16'hA5A5, WIDTH, 1);
      nss_high();

      // Reset in the middle of a word, then a clean frame.
      half = 8;
      nss_low();
      send_word(16'hFFFF, 9, 0);
      step(2);
      reset  = 1'b1;
      m_bits = 0;
      step(2);
      check_zero("midreset");
      nss = 1'b1;
      step(5);
      reset = 1'b0;
      step(20);
      nss_low();
      send_word(16'hCAFE, WIDTH, 0);
      send_word(16'h0F0F, WIDTH, 0);
      send_word(16'h8001, WIDTH, 0);
      send_word(16'h7EE7, WIDTH, 0);
      nss_high();

      // Random frames: random speed, length, glitches and partial-word aborts.
      for (int f = 0; f < 10; f++) begin
         half = $urandom_range(7, 10);
         nss_low();
         nw = $urandom_range(1, 6);
         for (int k = 0; k < nw; k++) begin
            rw = 16'($urandom);
            gl = (half == 10) && ($urandom_range(0, 2) == 0);
            send_word(rw, WIDTH, gl);
         end
         if ($urandom_range(0, 2) == 0) begin
            rw = 16'($urandom);
            send_word(rw, $urandom_range(1, WIDTH - 1), 0);
         end
         nss_high();
      end

      step(30);
      chk("a_words_outstanding", 32'(qa.size()), 0);
      chk("b_words_outstanding", 32'(qb.size()), 0);
      chk("a_frame_errors", err_a, err_exp);
      chk("b_frame_errors", err_b, err_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
